// File: rtl/mesh_seq_pkg.sv
// Shared types for the multi-mesh transform sequencer: FSM states and the per-slot pose record.
package mesh_seq_pkg;

   typedef enum logic [2:0] {IDLE, SCAN, LOAD, KICK, WAIT, FIN} state_e;

   typedef struct packed {
      logic [31:0] roll;
      logic [31:0] pitch;
      logic [31:0] yaw;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } pose_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/multi_mesh_xform_seq_if.sv
// Sequencer <-> transform-engine link: pose/count/control toward the engine, rebased memory addresses toward RAM/ROM.
interface multi_mesh_xform_seq_if #(
   parameter int AW = 32,
   parameter int CW = 16
);
   logic [31:0]   eng_roll, eng_pitch, eng_yaw, eng_x, eng_y, eng_z;
   logic [CW-1:0] eng_count;
   logic          eng_update_mvp;
   logic          eng_start;
   logic          eng_done;
   logic [AW-1:0] eng_read_addr;
   logic [AW-1:0] mem_read_addr;
   logic [AW-1:0] eng_write_addr;
   logic          eng_wren;
   logic [AW-1:0] mem_write_addr;
   logic          mem_wren;

   modport master (
      output eng_roll, eng_pitch, eng_yaw, eng_x, eng_y, eng_z, eng_count,
      output eng_update_mvp, eng_start, mem_read_addr, mem_write_addr, mem_wren,
      input  eng_done, eng_read_addr, eng_write_addr, eng_wren
   );

   modport slave (
      input  eng_roll, eng_pitch, eng_yaw, eng_x, eng_y, eng_z, eng_count,
      input  eng_update_mvp, eng_start, mem_read_addr, mem_write_addr, mem_wren,
      output eng_done, eng_read_addr, eng_write_addr, eng_wren
   );
endinterface

// File: rtl/mesh_slot_snapshot.sv
// Frame-start snapshot of every mesh slot plus an index mux presenting the slot currently being processed.
module mesh_slot_snapshot
   import mesh_seq_pkg::*;
#(
   parameter int NUM_MESH = 4,
   parameter int AW       = 32,
   parameter int CW       = 16,
   parameter int XW       = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   capture,
   input  logic [XW-1:0]          idx,
   input  logic [NUM_MESH-1:0]    mesh_en,
   input  logic [NUM_MESH*32-1:0] pose_roll,
   input  logic [NUM_MESH*32-1:0] pose_pitch,
   input  logic [NUM_MESH*32-1:0] pose_yaw,
   input  logic [NUM_MESH*32-1:0] pose_x,
   input  logic [NUM_MESH*32-1:0] pose_y,
   input  logic [NUM_MESH*32-1:0] pose_z,
   input  logic [NUM_MESH*AW-1:0] mesh_base,
   input  logic [NUM_MESH*CW-1:0] mesh_count,
   output pose_t                  cur_pose,
   output logic [AW-1:0]          cur_base,
   output logic [CW-1:0]          cur_count,
   output logic                   cur_en
);

   pose_t                pose_q  [NUM_MESH];
   pose_t                pose_d  [NUM_MESH];
   logic [AW-1:0]        base_q  [NUM_MESH];
   logic [AW-1:0]        base_d  [NUM_MESH];
   logic [CW-1:0]        count_q [NUM_MESH];
   logic [CW-1:0]        count_d [NUM_MESH];
   logic [NUM_MESH-1:0]  en_q, en_d;

   // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
   always_comb begin
      pose_d  = pose_q;
      base_d  = base_q;
      count_d = count_q;
      en_d    = en_q;
      if (capture) begin
         en_d = mesh_en;
         for (int i = 0; i < NUM_MESH; i++) begin
            pose_d[i]  = '{roll:  pose_roll[32*i +: 32],  pitch: pose_pitch[32*i +: 32],
                           yaw:   pose_yaw[32*i +: 32],   x:     pose_x[32*i +: 32],
                           y:     pose_y[32*i +: 32],     z:     pose_z[32*i +: 32]};
            base_d[i]  = mesh_base[AW*i +: AW];
            count_d[i] = mesh_count[CW*i +: CW];
         end
      end
   end

   // NOTE: non-blocking assignments only in clocked blocks, so every flop samples pre-edge values.
   // NOTE: the snapshot array is reset because outputs must read zero straight out of reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         en_q <= '0;
         for (int i = 0; i < NUM_MESH; i++) begin
            pose_q[i]  <= '0;
            base_q[i]  <= '0;
            count_q[i] <= '0;
         end
      end else begin
         en_q    <= en_d;
         pose_q  <= pose_d;
         base_q  <= base_d;
         count_q <= count_d;
      end
   end

   // idx == NUM_MESH (end of frame) selects nothing and yields zeros.
   always_comb begin
      cur_pose  = '0;
      cur_base  = '0;
      cur_count = '0;
      cur_en    = 1'b0;
      for (int i = 0; i < NUM_MESH; i++) begin
         if (idx == XW'(i)) begin
            cur_pose  = pose_q[i];
            cur_base  = base_q[i];
            cur_count = count_q[i];
            cur_en    = en_q[i];
         end
      end
   end

endmodule

// File: rtl/multi_mesh_xform_seq.sv
// Frame sequencer running the MVP engine once per enabled mesh, packing all output contiguously.
// Optional MESH_SEQ_STATS_EN adds a saturating frame_cycles counter output.
module multi_mesh_xform_seq
   import mesh_seq_pkg::*;
#(
   parameter int NUM_MESH  = 4,
   parameter int AW        = 32,
   parameter int CW        = 16,
   parameter int WR_STRIDE = 3,
   parameter int IW        = (NUM_MESH > 1) ? $clog2(NUM_MESH) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NUM_MESH-1:0]    mesh_en,
   input  logic [NUM_MESH*32-1:0] pose_roll,
   input  logic [NUM_MESH*32-1:0] pose_pitch,
   input  logic [NUM_MESH*32-1:0] pose_yaw,
   input  logic [NUM_MESH*32-1:0] pose_x,
   input  logic [NUM_MESH*32-1:0] pose_y,
   input  logic [NUM_MESH*32-1:0] pose_z,
   input  logic [NUM_MESH*AW-1:0] mesh_base,
   input  logic [NUM_MESH*CW-1:0] mesh_count,
   multi_mesh_xform_seq_if.master eng,
   output logic                   busy,
   output logic                   done,
   output logic [IW-1:0]          cur_mesh,
   output logic [AW-1:0]          words_written
`ifdef MESH_SEQ_STATS_EN
   ,
   output logic [31:0]            frame_cycles
`endif
);

   // One extra index bit so idx can reach NUM_MESH, the end-of-frame marker.
   localparam int XW = IW + 1;

   state_e        state_q, state_d;
   logic [XW-1:0] idx_q, idx_d;
   logic [AW-1:0] out_base_q, out_base_d;
   logic [AW-1:0] words_written_q, words_written_d;
   logic          capture, upd, kick;
   pose_t         cur_pose;
   logic [AW-1:0] cur_base;
   logic [CW-1:0] cur_count;
   logic          cur_en;

   mesh_slot_snapshot #(.NUM_MESH(NUM_MESH), .AW(AW), .CW(CW), .XW(XW)) u_snap (
      .clock(clock), .reset(reset), .capture(capture), .idx(idx_q), .mesh_en(mesh_en),
      .pose_roll(pose_roll), .pose_pitch(pose_pitch), .pose_yaw(pose_yaw),
      .pose_x(pose_x), .pose_y(pose_y), .pose_z(pose_z),
      .mesh_base(mesh_base), .mesh_count(mesh_count),
      .cur_pose(cur_pose), .cur_base(cur_base), .cur_count(cur_count), .cur_en(cur_en)
   );

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      out_base_d      = out_base_q;
      words_written_d = words_written_q;
      capture         = 1'b0;
      upd             = 1'b0;
      kick            = 1'b0;
      done            = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            capture    = 1'b1;
            idx_d      = '0;
            out_base_d = '0;
            state_d    = SCAN;
         end
         SCAN: begin
            if (idx_q == XW'(NUM_MESH))          state_d = FIN;
            else if (!cur_en || cur_count == '0) idx_d   = idx_q + XW'(1);
            else                                 state_d = LOAD;
         end
         LOAD: begin
            upd     = 1'b1;
            state_d = KICK;
         end
         KICK: begin
            kick    = 1'b1;
            state_d = WAIT;
         end
         WAIT: if (eng.eng_done) begin
            out_base_d = out_base_q + AW'(cur_count) * AW'(WR_STRIDE);
            idx_d      = idx_q + XW'(1);
            state_d    = SCAN;
         end
         FIN: begin
            words_written_d = out_base_q;
            done            = 1'b1;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         idx_q           <= '0;
         out_base_q      <= '0;
         words_written_q <= '0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         out_base_q      <= out_base_d;
         words_written_q <= words_written_d;
      end
   end

   assign busy               = (state_q != IDLE);
   assign cur_mesh           = idx_q[IW-1:0];
   assign words_written      = words_written_q;
   assign eng.eng_roll       = cur_pose.roll;
   assign eng.eng_pitch      = cur_pose.pitch;
   assign eng.eng_yaw        = cur_pose.yaw;
   assign eng.eng_x          = cur_pose.x;
   assign eng.eng_y          = cur_pose.y;
   assign eng.eng_z          = cur_pose.z;
   assign eng.eng_count      = cur_count;
   assign eng.eng_update_mvp = upd;
   assign eng.eng_start      = kick;
   assign eng.mem_read_addr  = eng.eng_read_addr + cur_base;
   assign eng.mem_write_addr = eng.eng_write_addr + out_base_q;
   assign eng.mem_wren       = eng.eng_wren && (state_q == WAIT);

`ifdef MESH_SEQ_STATS_EN
   // cyc_q equals the frame-relative cycle number, so FIN latches it plus one (inclusive count).
   logic [31:0] cyc_q, cyc_d, frame_cycles_q, frame_cycles_d;

   always_comb begin
      cyc_d          = cyc_q;
      frame_cycles_d = frame_cycles_q;
      if (state_q == IDLE) begin
         if (start) cyc_d = 32'd1;
      end else begin
         cyc_d = sat_inc32(cyc_q);
      end
      if (state_q == FIN) frame_cycles_d = sat_inc32(cyc_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cyc_q          <= '0;
         frame_cycles_q <= '0;
      end else begin
         cyc_q          <= cyc_d;
         frame_cycles_q <= frame_cycles_d;
      end
   end

   assign frame_cycles = frame_cycles_q;
`endif

endmodule

// File: tb/tb_multi_mesh_xform_seq.sv
// Randomized self-checking bench for multi_mesh_xform_seq with a cycle-level engine model and a frame-level reference.
module tb_multi_mesh_xform_seq;

   localparam int NUM_MESH = 4;
   localparam int AW       = 32;
   localparam int CW       = 16;
   localparam int STRIDE   = 3;
   localparam int IW       = 2;
   localparam int ENG_LAT  = 10;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [NUM_MESH-1:0]    mesh_en = '0;
   logic [NUM_MESH*32-1:0] pose_roll = '0, pose_pitch = '0, pose_yaw = '0;
   logic [NUM_MESH*32-1:0] pose_x = '0, pose_y = '0, pose_z = '0;
   logic [NUM_MESH*AW-1:0] mesh_base = '0;
   logic [NUM_MESH*CW-1:0] mesh_count = '0;
   logic                   busy, done;
   logic [IW-1:0]          cur_mesh;
   logic [AW-1:0]          words_written;
`ifdef MESH_SEQ_STATS_EN
   logic [31:0]            frame_cycles;
`endif

   always #5 clock = ~clock;

   multi_mesh_xform_seq_if #(.AW(AW), .CW(CW)) eng_if ();

   multi_mesh_xform_seq #(.NUM_MESH(NUM_MESH), .AW(AW), .CW(CW), .WR_STRIDE(STRIDE)) dut (
`ifdef MESH_SEQ_STATS_EN
      .frame_cycles(frame_cycles),
`endif
      .clock(clock), .reset(reset), .start(start), .mesh_en(mesh_en),
      .pose_roll(pose_roll), .pose_pitch(pose_pitch), .pose_yaw(pose_yaw),
      .pose_x(pose_x), .pose_y(pose_y), .pose_z(pose_z),
      .mesh_base(mesh_base), .mesh_count(mesh_count), .eng(eng_if),
      .busy(busy), .done(done), .cur_mesh(cur_mesh), .words_written(words_written)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Upstream stimulus and the frame snapshot the reference model works from.
   logic          m_en [NUM_MESH];
   logic [31:0]   m_pose [NUM_MESH][6];
   logic [AW-1:0] m_base [NUM_MESH];
   logic [CW-1:0] m_count [NUM_MESH];
   logic          s_en [NUM_MESH];
   logic [31:0]   s_pose [NUM_MESH][6];
   logic [AW-1:0] s_base [NUM_MESH];
   logic [CW-1:0] s_count [NUM_MESH];

   int            exp_slots[$];
   logic [AW-1:0] exp_wr[$];
   int            exp_n_act, exp_n_wr, exp_first_upd, exp_done_cyc;
   logic [AW-1:0] exp_words;

   bit mon_en = 1'b0;
   bit active = 1'b0;
   int upds, kicks, dones, wr_seen, frame_cyc, first_upd, first_kick, cur_slot;
   int rd_fix = -1;

   task automatic randomize_inputs();
      for (int i = 0; i < NUM_MESH; i++) begin
         m_en[i]    = 1'($urandom_range(0, 3) != 0);
         m_count[i] = CW'($urandom_range(0, 4));
         m_base[i]  = AW'($urandom);
         for (int f = 0; f < 6; f++) m_pose[i][f] = $urandom;
      end
   endtask

   task automatic set_slot(input int i, input bit en, input int cnt, input logic [AW-1:0] base);
      m_en[i]    = en;
      m_count[i] = CW'(cnt);
      m_base[i]  = base;
      for (int f = 0; f < 6; f++) m_pose[i][f] = $urandom;
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < NUM_MESH; i++) begin
         mesh_en[i]             = m_en[i];
         pose_roll[32*i +: 32]  = m_pose[i][0];
         pose_pitch[32*i +: 32] = m_pose[i][1];
         pose_yaw[32*i +: 32]   = m_pose[i][2];
         pose_x[32*i +: 32]     = m_pose[i][3];
         pose_y[32*i +: 32]     = m_pose[i][4];
         pose_z[32*i +: 32]     = m_pose[i][5];
         mesh_base[AW*i +: AW]  = m_base[i];
         mesh_count[CW*i +: CW] = m_count[i];
      end
   endtask

   // Frame-level reference: which slots run, where their output lands, and when things happen.
   task automatic build_model();
      int cyc, n, lat;
      logic [AW-1:0] base;
      exp_slots.delete();
      exp_wr.delete();
      base = '0; cyc = 1; exp_n_act = 0; exp_n_wr = 0; exp_first_upd = -1;
      for (int i = 0; i < NUM_MESH; i++) begin
         s_en[i] = m_en[i]; s_base[i] = m_base[i]; s_count[i] = m_count[i];
         for (int f = 0; f < 6; f++) s_pose[i][f] = m_pose[i][f];
         if (s_en[i] && s_count[i] != 0) begin
            if (exp_first_upd < 0) exp_first_upd = 2 + i;
            exp_slots.push_back(i);
            n = int'(s_count[i]) * STRIDE;
            for (int k = 0; k < n; k++) exp_wr.push_back(base + AW'(k));
            base += AW'(n);
            lat = (n < ENG_LAT) ? ENG_LAT : n;
            cyc += 3 + lat;
            exp_n_act++;
            exp_n_wr += n;
         end else begin
            cyc += 1;
         end
      end
      exp_done_cyc = cyc + 1;
      exp_words    = base;
   endtask

   // Engine model: on eng_start, writes count*STRIDE local words then pulses done.
   initial begin
      eng_if.eng_done = 1'b0; eng_if.eng_wren = 1'b0;
      eng_if.eng_read_addr = '0; eng_if.eng_write_addr = '0;
      forever begin
         @(negedge clock);
         if (eng_if.eng_start && !reset) begin
            int n, lat;
            n   = int'(eng_if.eng_count) * STRIDE;
            lat = (n < ENG_LAT) ? ENG_LAT : n;
            for (int c = 0; c < lat; c++) begin
               @(posedge clock);
               if (reset) break;
               #1;
               eng_if.eng_wren       = (c < n);
               eng_if.eng_write_addr = AW'(c);
               eng_if.eng_read_addr  = (rd_fix >= 0) ? AW'(rd_fix) : AW'($urandom_range(0, 1023));
               eng_if.eng_done       = (c == lat - 1);
            end
            if (!reset) begin
               @(posedge clock);
               #1;
            end
            eng_if.eng_wren = 1'b0; eng_if.eng_done = 1'b0;
         end
      end
   end

   // Monitor: pulse counts, per-slot engine-side values and output write addresses.
   initial forever begin
      @(negedge clock);
      if (mon_en) begin
         if (eng_if.eng_update_mvp) begin
            upds++;
            if (first_upd < 0) first_upd = frame_cyc;
            if (exp_slots.size() > 0) begin
               cur_slot = exp_slots.pop_front();
               active   = 1'b1;
            end
         end
         if (active) begin
            check("eng_roll",  eng_if.eng_roll,  s_pose[cur_slot][0]);
            check("eng_pitch", eng_if.eng_pitch, s_pose[cur_slot][1]);
            check("eng_yaw",   eng_if.eng_yaw,   s_pose[cur_slot][2]);
            check("eng_x",     eng_if.eng_x,     s_pose[cur_slot][3]);
            check("eng_y",     eng_if.eng_y,     s_pose[cur_slot][4]);
            check("eng_z",     eng_if.eng_z,     s_pose[cur_slot][5]);
            check("eng_count", eng_if.eng_count, s_count[cur_slot]);
            check("cur_mesh",  cur_mesh,         64'(cur_slot));
            check("mem_read_addr", eng_if.mem_read_addr, s_base[cur_slot] + eng_if.eng_read_addr);
         end
         if (eng_if.eng_start) begin
            kicks++;
            if (first_kick < 0) first_kick = frame_cyc;
         end
         if (eng_if.mem_wren) begin
            wr_seen++;
            if (exp_wr.size() > 0) check("mem_write_addr", eng_if.mem_write_addr, exp_wr.pop_front());
         end
         if (active && eng_if.eng_done) active = 1'b0;
         if (done) dones++;
      end
      frame_cyc++;
   end

   task automatic begin_frame();
      @(posedge clock);
      #1;
      apply_inputs();
      build_model();
      upds = 0; kicks = 0; dones = 0; wr_seen = 0;
      first_upd = -1; first_kick = -1; frame_cyc = 0; active = 1'b0;
      start = 1'b1;
   endtask

   task automatic run_frame(input string tag, input bit restart);
      int d;
      bit got;
      begin_frame();
      d = 0; got = 1'b0;
      while (d < 3000) begin
         @(negedge clock);
         if (d == 1) start = 1'b0;
         if (restart && d == 4) begin
            randomize_inputs();
            apply_inputs();
            start = 1'b1;
         end
         if (restart && d == 5) start = 1'b0;
         if (done) begin
            got = 1'b1;
            break;
         end
         d++;
      end
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check({tag, ":done_seen"},  got,       1);
      check({tag, ":done_cycle"}, d,         exp_done_cyc);
      check({tag, ":upd_pulses"}, upds,      exp_n_act);
      check({tag, ":kick_pulses"}, kicks,    exp_n_act);
      check({tag, ":done_pulses"}, dones,    1);
      check({tag, ":writes"},     wr_seen,   exp_n_wr);
      check({tag, ":words"},      words_written, exp_words);
      check({tag, ":idle"},       busy,      0);
      if (exp_n_act > 0) begin
         check({tag, ":upd_latency"},  first_upd,  exp_first_upd);
         check({tag, ":kick_latency"}, first_kick, exp_first_upd + 1);
      end
`ifdef MESH_SEQ_STATS_EN
      check({tag, ":frame_cycles"}, frame_cycles, d + 1);
`endif
   endtask

   task automatic reset_in_wait();
      int w;
      for (int i = 0; i < NUM_MESH; i++) set_slot(i, 1'b1, 3, AW'($urandom));
      begin_frame();
      w = 0;
      @(negedge clock);
      @(negedge clock);
      start = 1'b0;
      while (kicks == 0 && w < 100) begin
         @(negedge clock);
         w++;
      end
      check("rst:kick_seen", kicks, 1);
      repeat (3) @(negedge clock);
      check("rst:busy_before", busy, 1);
      check("rst:wren_before", eng_if.mem_wren, 1);
      mon_en = 1'b0;
      reset  = 1'b1;
      #1;
      check("rst:busy_async",  busy,              0);
      check("rst:start_async", eng_if.eng_start,  0);
      check("rst:wren_async",  eng_if.mem_wren,   0);
      check("rst:upd_async",   eng_if.eng_update_mvp, 0);
      exp_slots.delete();
      exp_wr.delete();
      active = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("rst:words_cleared", words_written, 0);
      mon_en = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < NUM_MESH; i++) set_slot(i, 1'b0, 0, '0);
      repeat (2) @(negedge clock);
      check("reset:busy",      busy,                  0);
      check("reset:done",      done,                  0);
      check("reset:words",     words_written,         0);
      check("reset:cur_mesh",  cur_mesh,              0);
      check("reset:eng_roll",  eng_if.eng_roll,       0);
      check("reset:eng_count", eng_if.eng_count,      0);
      check("reset:upd",       eng_if.eng_update_mvp, 0);
      check("reset:kick",      eng_if.eng_start,      0);
      check("reset:wren",      eng_if.mem_wren,       0);
`ifdef MESH_SEQ_STATS_EN
      check("reset:frame_cycles", frame_cycles, 0);
`endif
      reset  = 1'b0;
      mon_en = 1'b1;

      set_slot(0, 1'b1, 2, AW'($urandom));
      set_slot(1, 1'b1, 1, AW'($urandom));
      set_slot(2, 1'b1, 3, AW'($urandom));
      set_slot(3, 1'b1, 2, AW'($urandom));
      run_frame("all_en", 1'b0);

      for (int i = 0; i < NUM_MESH; i++) set_slot(i, 1'b0, 2, AW'($urandom));
      run_frame("all_dis", 1'b0);

      set_slot(0, 1'b1, 2, AW'($urandom));
      set_slot(1, 1'b1, 0, AW'($urandom));
      set_slot(2, 1'b0, 3, AW'($urandom));
      set_slot(3, 1'b1, 1, AW'(32'h40));
      rd_fix = 5;
      run_frame("skip", 1'b0);
      rd_fix = -1;

      for (int i = 0; i < NUM_MESH; i++) set_slot(i, 1'b1, 2, AW'($urandom));
      run_frame("restart", 1'b1);

      reset_in_wait();
      randomize_inputs();
      m_en[0] = 1'b1; m_count[0] = CW'(2);
      run_frame("post_reset", 1'b0);

      set_slot(0, 1'b0, 0, '0);
      set_slot(1, 1'b1, 2, AW'($urandom));
      set_slot(2, 1'b1, 3, AW'($urandom));
      set_slot(3, 1'b0, 1, '0);
      run_frame("two_mesh", 1'b0);

      for (int r = 0; r < 20; r++) begin
         randomize_inputs();
         run_frame($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
